// File: rtl/sata_link_tx_conditioner.sv
// sata_link_tx_conditioner: ALIGN insertion and CONT/junk repeat suppression between SATA link layer and PHY
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   phy_ready_in      PHY link up; low forces OFFLINE and clears all state
//   cont_en           enables CONT/junk suppression of repeated primitives
//   link_din/is_k     dword and primitive flag from the link layer
//   link_ready        link_din consumed at this posedge
//   phy_dout/is_k     registered dword and K mask to the PHY
//   align_active      high while an inserted ALIGN pair is on phy_dout
module sata_link_tx_conditioner #(
  parameter int          ALIGN_INTERVAL = 256,
  parameter logic [31:0] LFSR_SEED      = 32'hC2D2768D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        phy_ready_in,
  input  logic        cont_en,
  input  logic [31:0] link_din,
  input  logic        link_is_k,
  output logic        link_ready,
  output logic [31:0] phy_dout,
  output logic [3:0]  phy_is_k,
  output logic        align_active
);
  localparam logic [31:0] PRIM_ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] PRIM_CONT  = 32'h9999AA7C;
  localparam logic [31:0] PRIM_SOF   = 32'h3737B57C;
  localparam logic [31:0] PRIM_EOF   = 32'hD5D5B57C;
  localparam int          CW         = $clog2(ALIGN_INTERVAL);
  typedef enum logic [1:0] {PASS, ALIGN0, ALIGN1, OFFLINE} state_t;
  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] last_q, last_d, lfsr_q, lfsr_d, dout_q, dout_d;
  logic [1:0]  rep_q, rep_d;
  logic [3:0]  isk_q, isk_d;
  logic        aa_q, aa_d;
  logic        special, repeat_hit;
  assign link_ready   = phy_ready_in && !rst && (state_q == PASS);
  assign phy_dout     = dout_q;
  assign phy_is_k     = isk_q;
  assign align_active = aa_q;
  assign special    = (link_din == PRIM_SOF) || (link_din == PRIM_EOF) ||
                      (link_din == PRIM_ALIGN) || (link_din == PRIM_CONT);
  assign repeat_hit = link_is_k && !special && (link_din == last_q);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    rep_d   = rep_q;
    lfsr_d  = lfsr_q;
    dout_d  = PRIM_ALIGN;
    isk_d   = 4'b0001;
    aa_d    = 1'b0;
    if (!phy_ready_in) begin
      state_d = OFFLINE;
      cnt_d   = '0;
      last_d  = '0;
      rep_d   = '0;
      lfsr_d  = LFSR_SEED;
    end else begin
      case (state_q)
        PASS: begin
          last_d  = link_is_k ? link_din : '0;
          rep_d   = !link_is_k ? 2'd0 : !repeat_hit ? 2'd1 : (rep_q == 2'd3) ? 2'd3 : rep_q + 2'd1;
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == CW'(ALIGN_INTERVAL - 3)) ? ALIGN0 : PASS;
          dout_d  = link_din;
          isk_d   = {3'b000, link_is_k};
          // rep_cnt saturates at 3, so the 2->3 step marks the single CONT; staying at 3 means junk
          if (cont_en && rep_d == 2'd3) begin
            dout_d = (rep_q == 2'd2) ? PRIM_CONT : lfsr_q;
            isk_d  = (rep_q == 2'd2) ? 4'b0001 : 4'b0000;
            lfsr_d = (rep_q == 2'd2) ? lfsr_q : {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
          end
        end
        ALIGN0: begin
          state_d = ALIGN1;
          aa_d    = 1'b1;
        end
        ALIGN1: begin
          state_d = PASS;
          cnt_d   = '0;
          aa_d    = 1'b1;
        end
        default: state_d = PASS;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PASS;
      cnt_q   <= '0;
      last_q  <= '0;
      rep_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      dout_q  <= PRIM_ALIGN;
      isk_q   <= 4'b0001;
      aa_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      rep_q   <= rep_d;
      lfsr_q  <= lfsr_d;
      dout_q  <= dout_d;
      isk_q   <= isk_d;
      aa_q    <= aa_d;
    end
  end
endmodule

// File: tb/tb_sata_link_tx_conditioner.sv
// tb_sata_link_tx_conditioner: randomized and directed checks against a cycle-level reference model
module tb_sata_link_tx_conditioner;
  localparam int          AI      = 16;
  localparam logic [31:0] SEED    = 32'hC2D2768D;
  localparam logic [31:0] P_ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] P_CONT  = 32'h9999AA7C;
  localparam logic [31:0] P_SYNC  = 32'hB5B5957C;
  localparam logic [31:0] P_XRDY  = 32'h5757B57C;
  localparam logic [31:0] P_HOLD  = 32'hD5D5AA7C;
  localparam logic [31:0] P_RRDY  = 32'h4A4A957C;
  localparam logic [31:0] P_SOF   = 32'h3737B57C;
  localparam logic [31:0] P_EOF   = 32'hD5D5B57C;
  logic        clk = 1'b0;
  logic        rst, phy_ready_in, cont_en, link_is_k, link_ready, align_active;
  logic [31:0] link_din, phy_dout;
  logic [3:0]  phy_is_k;
  int          checks = 0;
  int          errors = 0;
  logic [32:0] q[$];
  logic        m_off, m_aa;
  int          m_al, m_sent, m_run;
  logic [31:0] m_prim, m_lfsr, m_dout;
  logic [3:0]  m_isk;
  logic [31:0] prims [8] = '{P_SYNC, P_HOLD, P_RRDY, P_XRDY, P_SOF, P_EOF, P_ALIGN, P_CONT};
  sata_link_tx_conditioner #(.ALIGN_INTERVAL(AI), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .phy_ready_in(phy_ready_in), .cont_en(cont_en),
    .link_din(link_din), .link_is_k(link_is_k), .link_ready(link_ready),
    .phy_dout(phy_dout), .phy_is_k(phy_is_k), .align_active(align_active)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
  endfunction
  function automatic bit never_repeat(input logic [31:0] d);
    return d == P_SOF || d == P_EOF || d == P_ALIGN || d == P_CONT;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic m_clear(input logic off);
    m_off  = off;
    m_al   = 0;
    m_sent = 0;
    m_run  = 0;
    m_prim = '0;
    m_lfsr = SEED;
    m_dout = P_ALIGN;
    m_isk  = 4'b0001;
    m_aa   = 1'b0;
  endtask
  task automatic cyc();
    logic [32:0] w;
    logic        rdy;
    w = (q.size() > 0) ? q[0] : {1'b0, 32'($urandom())};
    link_is_k = w[32];
    link_din  = w[31:0];
    #1;
    rdy = !rst && phy_ready_in && !m_off && m_al == 0;
    chk("link_ready", 32'(link_ready), 32'(rdy));
    @(posedge clk);
    if (rst) m_clear(1'b0);
    else if (!phy_ready_in) m_clear(1'b1);
    else if (m_off) begin
      m_off = 1'b0; m_dout = P_ALIGN; m_isk = 4'b0001; m_aa = 1'b0;
    end else if (m_al > 0) begin
      m_dout = P_ALIGN; m_isk = 4'b0001; m_aa = 1'b1;
      m_al--;
      if (m_al == 0) m_sent = 0;
    end else begin
      if (q.size() > 0) void'(q.pop_front());
      m_aa = 1'b0;
      if (!w[32]) m_run = 0;
      else if (!never_repeat(w[31:0]) && m_run > 0 && w[31:0] == m_prim) m_run++;
      else begin
        m_prim = w[31:0];
        m_run  = 1;
      end
      if (!cont_en || m_run < 3) begin
        m_dout = w[31:0]; m_isk = {3'b000, w[32]};
      end else if (m_run == 3) begin
        m_dout = P_CONT; m_isk = 4'b0001;
      end else begin
        m_dout = m_lfsr; m_isk = 4'b0000;
        m_lfsr = lfsr_next(m_lfsr);
      end
      m_sent++;
      if (m_sent == AI - 2) m_al = 2;
    end
    #1;
    chk("phy_dout", phy_dout, m_dout);
    chk("phy_is_k", 32'(phy_is_k), 32'(m_isk));
    chk("align_active", 32'(align_active), 32'(m_aa));
  endtask
  task automatic drain();
    for (int i = 0; i < 2000 && q.size() > 0; i++) cyc();
    chk("drain", 32'(q.size()), 32'd0);
  endtask
  task automatic push_n(input logic k, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) q.push_back({k, d});
  endtask
  task automatic push_rand();
    int sel, len;
    sel = $urandom_range(9);
    len = $urandom_range(7, 1);
    if (sel < 8) push_n(1'b1, prims[sel], len);
    else for (int i = 0; i < len; i++) q.push_back({1'b0, 32'($urandom())});
  endtask
  initial begin
    rst = 1'b1; phy_ready_in = 1'b1; cont_en = 1'b1; link_din = '0; link_is_k = 1'b0;
    m_clear(1'b0);
    @(posedge clk); #1;
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) q.push_back({1'b0, 32'h1000 + 32'(i)});
    drain();
    push_n(1'b1, P_SYNC, 6); push_n(1'b1, P_XRDY, 1);
    drain();
    cont_en = 1'b0;
    push_n(1'b1, P_SYNC, 6); push_n(1'b1, P_XRDY, 1);
    drain();
    cont_en = 1'b1;
    push_n(1'b1, P_HOLD, 10); push_n(1'b1, P_RRDY, 1);
    drain();
    push_n(1'b1, P_SOF, 2);
    for (int i = 0; i < 3; i++) push_n(1'b0, 32'hA000 + 32'(i), 2);
    push_n(1'b1, P_EOF, 2);
    drain();
    for (int i = 0; i < 200; i++)
      q.push_back((i % 40 < 8) ? {1'b1, P_HOLD} : {1'b0, 32'hB000 + 32'(i)});
    for (int i = 0; i < 100; i++) cyc();
    phy_ready_in = 1'b0;
    repeat (5) cyc();
    phy_ready_in = 1'b1;
    drain();
    for (int i = 0; i < 3000; i++) begin
      if (q.size() < 4) push_rand();
      rst          = ($urandom_range(399) == 0);
      phy_ready_in = ($urandom_range(149) != 0);
      cont_en      = ($urandom_range(9) != 0);
      cyc();
    end
    rst = 1'b0; phy_ready_in = 1'b1;
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sata_link_tx_conditioner.md
Name: sata_link_tx_conditioner

Overview:
- Sits directly downstream of the link-layer write path, between its tx_dout/tx_is_k and the PHY transmit interface.
- Inserts ALIGN primitive pairs at a fixed dword cadence and back-pressures the link layer through link_ready while doing so.
- Suppresses repeated primitives with CONT followed by scrambled junk dwords.
- Drives the registered dword and K-byte mask to the PHY.

Parameters:
ALIGN_INTERVAL, 256, total dwords per ALIGN period: (ALIGN_INTERVAL-2) link dwords followed by 2 ALIGNs; legal range 8..1024
LFSR_SEED, 32'hC2D2768D, junk-generator value after reset and after every phy_ready_in drop

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
phy_ready_in  in  1  PHY link up (OOB complete)
cont_en  in  1  enables CONT/junk suppression; sampled every cycle
link_din  in  32  dword from link layer (primitive or scrambled data)
link_is_k  in  1  link_din is a primitive (K28.x in byte 0)
link_ready  out  1  link_din consumed at this posedge; link holds link_din while low
phy_dout  out  32  dword to PHY, registered
phy_is_k  out  4  K mask to PHY, 4'b0001 for primitives, 4'b0000 for data/junk
align_active  out  1  high while an ALIGN pair is being emitted (debug)

Behaviour:
- Reset: phy_dout=`PRIM_ALIGN, phy_is_k=4'b0001, link_ready=0, align_active=0, align counter=0, repeat tracker cleared, LFSR=LFSR_SEED.
- link_ready is combinational: phy_ready_in && !rst && (state==PASS).
- The link layer advances only on cycles with link_ready=1.
- Output latency is 1 cycle: the dword consumed at posedge N appears on phy_dout after posedge N.
- FSM states:
  - PASS: consume link_din and increment align_cnt. When align_cnt reaches ALIGN_INTERVAL-3 on a consume, go to ALIGN0.
  - ALIGN0: output `PRIM_ALIGN, link_ready=0, go to ALIGN1.
  - ALIGN1: output `PRIM_ALIGN, link_ready=0, align_cnt<=0, go to PASS.
  - OFFLINE: entered from any state whenever phy_ready_in=0. Output `PRIM_ALIGN with is_k=0001, link_ready=0. Clears align_cnt, the repeat tracker and the LFSR. Returns to PASS on the first cycle with phy_ready_in=1; counting restarts at 0.
  - The ALIGN cadence is therefore exactly ALIGN_INTERVAL-2 link dwords then 2 ALIGNs, repeating.
- Repeat tracker (consumed dwords only; ALIGN cycles neither count nor break a run):
  - Holds last_prim[31:0] and rep_cnt[1:0], saturating at 3.
  - A consumed primitive equal to last_prim and not SOF/EOF/ALIGN/CONT increments rep_cnt.
  - Any other primitive loads last_prim and sets rep_cnt=1.
  - A consumed data dword (link_is_k=0) clears the tracker.
- Output selection in PASS:
  - rep_cnt (after update) = 1 or 2: pass link_din through.
  - rep_cnt = 3 on the first repeat beyond two: emit `PRIM_CONT, is_k=0001.
  - Subsequent repeats: emit LFSR junk, is_k=0000.
  - If cont_en=0: pass link_din through unconditionally; the tracker still updates.
- A run interrupted by an ALIGN pair resumes junk (not CONT) after ALIGN1.
- A new, different primitive terminates the run and is passed through immediately.
- LFSR:
  - 32-bit Fibonacci, polynomial x^32+x^22+x^2+x+1.
  - Advances exactly once per junk dword emitted; holds otherwise.
- Data dwords are never altered. SOF, EOF, ALIGN and CONT received from the link are always passed through and never counted as repeatable.
- Simultaneous events:
  - A phy_ready_in drop overrides everything; an ALIGN pair in progress is abandoned.
  - If the align threshold and a CONT decision coincide, the CONT/junk dword for the consumed input is emitted first, then ALIGN0.
- rst mid-operation: all state returns to reset values on the next edge; nothing is consumed during the reset cycle.

Test Plan:
1. Reset, phy_ready_in=1, link streams incrementing data dwords with ALIGN_INTERVAL=16 -> phy_dout shows 14 data dwords, 2 ALIGNs, repeating; link_ready low exactly on the 2 ALIGN cycles; no data dword lost or duplicated.
2. cont_en=1, link sends `PRIM_SYNC ×6 then `PRIM_X_RDY -> phy_dout: SYNC, SYNC, CONT, junk, junk, junk (is_k=0, LFSR sequence from LFSR_SEED), X_RDY.
3. cont_en=0, same stimulus -> six SYNCs then X_RDY verbatim; LFSR value unchanged.
4. Run of 10 `PRIM_HOLD with an ALIGN pair falling after the 4th consumed HOLD -> HOLD, HOLD, CONT, junk, ALIGN, ALIGN, junk…; no second CONT.
5. SOF, data ×3, EOF, each repeated twice -> all passed verbatim, no CONT emitted, phy_is_k 0001 only on SOF/EOF.
6. phy_ready_in dropped for 5 cycles mid-run of 200 dwords -> ALIGN output with link_ready=0 for those cycles; cadence restarts from count 0 after recovery; junk restarts at LFSR_SEED.
